// File: rtl/serial_load_assembler_pkg.sv
// serial_load_assembler_pkg: shared state encoding and bit-counter sizing for the serial load assembler.
package serial_load_assembler_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    LOAD  = ST_LOAD
  } state_t;
  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/serial_load_if.sv
// serial_load_if: serial bit stream in, assembled word and status out.
interface serial_load_if #(
  parameter int N     = 3,
  parameter int CNT_W = 8
);
  logic             sin_valid;
  logic             sin_data;
  logic             sin_start;
  logic             abort;
  logic             load;
  logic [N-1:0]     D;
  logic             busy;
  logic             frame_err;
  logic [CNT_W-1:0] word_count;
  modport master (
    output sin_valid, sin_data, sin_start, abort,
    input  load, D, busy, frame_err, word_count
  );
  modport slave (
    input  sin_valid, sin_data, sin_start, abort,
    output load, D, busy, frame_err, word_count
  );
endinterface

// File: rtl/serial_load_shifter.sv
// serial_load_shifter: N-bit shift register with bit counter; clr together with en restarts at bit 0.
module serial_load_shifter #(
  parameter int N         = 3,
  parameter bit MSB_FIRST = 1,
  parameter int CW        = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          bit_in,
  output logic [N-1:0]  word_next,
  output logic [CW-1:0] count
);
  logic [N-1:0] word;
  logic [N-1:0] base;
  assign base = clr ? '0 : word;
  // word_next is the value after this edge's shift, so the top can latch D in the same edge
  generate
    if (N == 1) begin : g_one
      assign word_next = bit_in;
    end else if (MSB_FIRST) begin : g_msb
      assign word_next = {base[N-2:0], bit_in};
    end else begin : g_lsb
      assign word_next = {bit_in, base[N-1:1]};
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word  <= '0;
      count <= '0;
    end else if (en) begin
      word  <= word_next;
      count <= (clr ? '0 : count) + 1'b1;
    end else if (clr) begin
      word  <= '0;
      count <= '0;
    end
  end
endmodule

// File: rtl/serial_load_assembler.sv
// serial_load_assembler: assembles framed serial bits into an N-bit word and pulses load once per word.
module serial_load_assembler
  import serial_load_assembler_pkg::*;
#(
  parameter int N         = 3,
  parameter bit MSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_load_if.slave  bus
);
  localparam int CW = cnt_bits(N);
  state_t       st;
  state_t       nxt;
  logic         in_shift;
  logic         en;
  logic         clr;
  logic         done;
  logic         err;
  logic [N-1:0] word_next;
  logic [CW-1:0] count;
  assign in_shift = st == SHIFT;
  // outside SHIFT a start bit always begins a fresh frame; inside, a start bit restarts it
  assign clr  = !in_shift | bus.abort | (bus.sin_valid & bus.sin_start);
  assign en   = bus.sin_valid & (in_shift ? !bus.abort : bus.sin_start);
  assign done = en && ((clr ? '0 : count) == CW'(N - 1));
  assign err  = bus.sin_valid & (in_shift ? (!bus.abort & bus.sin_start) : !bus.sin_start);
  assign nxt  = done ? LOAD : (en | (in_shift & !bus.abort)) ? SHIFT : IDLE;
  serial_load_shifter #(.N(N), .MSB_FIRST(MSB_FIRST), .CW(CW)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .bit_in    (bus.sin_data),
    .word_next (word_next),
    .count     (count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= IDLE;
      bus.load       <= 1'b0;
      bus.D          <= '0;
      bus.busy       <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.word_count <= '0;
    end else begin
      st            <= nxt;
      bus.load      <= nxt == LOAD;
      bus.busy      <= nxt == SHIFT;
      bus.frame_err <= err;
      if (done) bus.D <= word_next;
      if (st == LOAD) bus.word_count <= bus.word_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_load_assembler.sv
// tb_serial_load_assembler: MSB-first (CNT_W=2) and LSB-first instances driven in lockstep, checked by a load scoreboard.
module tb_serial_load_assembler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  serial_load_if #(.N(3), .CNT_W(2)) if0 ();
  serial_load_if #(.N(3), .CNT_W(8)) if1 ();
  serial_load_assembler #(.N(3), .MSB_FIRST(1), .CNT_W(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  serial_load_assembler #(.N(3), .MSB_FIRST(0), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  int total = 0;
  int bad = 0;
  int errs0 = 0;
  int errs1 = 0;
  logic [4:0]  q0[$];
  logic [10:0] q1[$];
  logic [4:0]  e0;
  logic [10:0] e1;
  logic        pend0 = 1'b0, pend1 = 1'b0, prev0 = 1'b0, prev1 = 1'b0;
  logic [1:0]  c0;
  logic [7:0]  c1;
  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic d, input logic s, input logic a);
    if0.sin_valid = v; if0.sin_data = d; if0.sin_start = s; if0.abort = a;
    if1.sin_valid = v; if1.sin_data = d; if1.sin_start = s; if1.abort = a;
  endtask
  task automatic step(input logic v, input logic d, input logic s, input logic a);
    drive(v, d, s, a);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic frame3(input logic b0, input logic b1, input logic b2);
    step(1'b1, b0, 1'b1, 1'b0);
    step(1'b1, b1, 1'b0, 1'b0);
    step(1'b1, b2, 1'b0, 1'b0);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_word(input logic [2:0] w0, input logic [1:0] k0, input logic [2:0] w1, input logic [7:0] k1);
    q0.push_back({w0, k0});
    q1.push_back({w1, k1});
  endtask
  // scoreboard: each load pops one expected word; the count is checked the cycle after load
  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.frame_err) errs0++;
      if (if1.frame_err) errs1++;
      if (pend0) begin check("count0", int'(if0.word_count), int'(c0)); pend0 = 1'b0; end
      if (pend1) begin check("count1", int'(if1.word_count), int'(c1)); pend1 = 1'b0; end
      if (if0.load && prev0) begin total++; bad++; $display("FAIL load0_width: load high two cycles"); end
      if (if1.load && prev1) begin total++; bad++; $display("FAIL load1_width: load high two cycles"); end
      if (if0.load) begin
        if (q0.size() == 0) begin total++; bad++; $display("FAIL load0_unexpected: D=%0d", if0.D); end
        else begin e0 = q0.pop_front(); check("D0", int'(if0.D), int'(e0[4:2])); c0 = e0[1:0]; pend0 = 1'b1; end
      end
      if (if1.load) begin
        if (q1.size() == 0) begin total++; bad++; $display("FAIL load1_unexpected: D=%0d", if1.D); end
        else begin e1 = q1.pop_front(); check("D1", int'(if1.D), int'(e1[10:8])); c1 = e1[7:0]; pend1 = 1'b1; end
      end
      prev0 = if0.load;
      prev1 = if1.load;
    end else begin
      prev0 = 1'b0;
      prev1 = 1'b0;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("reset0", int'({if0.load, if0.D, if0.busy, if0.frame_err, if0.word_count}), 0);
    check("reset1", int'({if1.load, if1.D, if1.busy, if1.frame_err, if1.word_count}), 0);
    rst_n = 1'b1;
    expect_word(3'b101, 2'd1, 3'b101, 8'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("busy_t1_a", int'(if0.busy), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("busy_t1_b", int'(if0.busy), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("load_t1", int'(if0.load), 1);
    check("busy_t1_load", int'(if0.busy), 0);
    idle(1);
    check("load_t1_end", int'(if0.load), 0);
    idle(1);
    expect_word(3'b110, 2'd2, 3'b011, 8'd2);
    frame3(1'b1, 1'b1, 1'b0);
    idle(2);
    expect_word(3'b011, 2'd3, 3'b110, 8'd3);
    expect_word(3'b100, 2'd0, 3'b001, 8'd4);
    frame3(1'b0, 1'b1, 1'b1);
    frame3(1'b1, 1'b0, 1'b0);
    idle(2);
    check("err_b2b", errs0 + errs1, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("err_idle_pulse", int'(if0.frame_err), 1);
    idle(1);
    check("err_idle_end", int'(if0.frame_err), 0);
    check("errs0_idle", errs0, 1);
    check("D_after_err", int'(if0.D), 3'b100);
    expect_word(3'b010, 2'd1, 3'b010, 8'd5);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    frame3(1'b0, 1'b1, 1'b0);
    idle(2);
    check("errs0_restart", errs0, 2);
    check("errs1_restart", errs1, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("busy_pre_abort", int'(if0.busy), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("busy_abort", int'(if0.busy), 0);
    idle(2);
    check("D_abort0", int'(if0.D), 3'b010);
    check("errs0_abort", errs0, 2);
    expect_word(3'b101, 2'd2, 3'b101, 8'd6);
    frame3(1'b1, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("busy_pre_rst", int'(if1.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst0", int'({if0.load, if0.D, if0.busy, if0.frame_err, if0.word_count}), 0);
    check("async_rst1", int'({if1.load, if1.D, if1.busy, if1.frame_err, if1.word_count}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_word(3'b001, 2'd1, 3'b100, 8'd1);
    frame3(1'b0, 1'b0, 1'b1);
    idle(2);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
